// File: rtl/alu_function_sequencer.sv
// ALU sequencer: captures a one-hot function select and operands on start, waits a
// settle interval, then latches result and flags and pulses done.
module alu_function_sequencer #(
   parameter int unsigned WIDTH         = 8,
   parameter int unsigned SETTLE_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [7:0]       op_onehot,
   input  logic [WIDTH-1:0] b_reg,
   input  logic [WIDTH-1:0] c_reg,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             sign,
   output logic             op_error
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      LATCH  = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [7:0]       op_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] c_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             carry_q;
   logic             zero_q;
   logic             sign_q;
   logic             op_error_q;

   logic [WIDTH:0]   ext_d;
   logic [WIDTH-1:0] result_d;
   logic             carry_d;
   logic             op_error_d;

   // Any select that is not exactly one-hot falls to the default arm and yields zero.
   always_comb begin
      ext_d = '0;
      case (op_q)
         8'b1000_0000: ext_d = {1'b0, b_q} + {1'b0, c_q};
         8'b0100_0000: ext_d = {1'b0, b_q} + (WIDTH+1)'(1);
         8'b0010_0000: ext_d = {1'b0, b_q & c_q};
         8'b0001_0000: ext_d = {1'b0, b_q | c_q};
         8'b0000_1000: ext_d = {1'b0, b_q ^ c_q};
         8'b0000_0100: ext_d = {1'b0, ~b_q};
         8'b0000_0010: ext_d = {1'b0, b_q[WIDTH-2:0], b_q[WIDTH-1]};
         default:      ext_d = '0;
      endcase
      result_d   = ext_d[WIDTH-1:0];
      carry_d    = ext_d[WIDTH];
      op_error_d = (op_q == 8'd0) || ((op_q & (op_q - 8'd1)) != 8'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         op_q       <= '0;
         b_q        <= '0;
         c_q        <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         result_q   <= '0;
         carry_q    <= 1'b0;
         zero_q     <= 1'b0;
         sign_q     <= 1'b0;
         op_error_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  op_q    <= op_onehot;
                  b_q     <= b_reg;
                  c_q     <= c_reg;
                  cnt_q   <= CNT_LOAD;
                  busy_q  <= 1'b1;
                  state_q <= SETTLE;
               end
            end
            SETTLE: begin
               if (cnt_q == 4'd0) begin
                  state_q <= LATCH;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            LATCH: begin
               result_q   <= result_d;
               carry_q    <= carry_d;
               zero_q     <= (result_d == '0);
               sign_q     <= result_d[WIDTH-1];
               op_error_q <= op_error_d;
               done_q     <= 1'b1;
               busy_q     <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign result   = result_q;
   assign carry    = carry_q;
   assign zero     = zero_q;
   assign sign     = sign_q;
   assign op_error = op_error_q;

endmodule

// File: tb/tb_alu_function_sequencer.sv
// Directed bench for alu_function_sequencer: per-cycle comparison against an
// operation-level reference model, plus hand-computed literal expectations.
module tb_alu_function_sequencer;

   localparam int W      = 8;
   localparam int SETTLE = 3;
   localparam int LAT    = SETTLE + 2;  // negedges from driving start to seeing done

   localparam logic [7:0] OP_ADD = 8'b1000_0000;
   localparam logic [7:0] OP_INC = 8'b0100_0000;
   localparam logic [7:0] OP_AND = 8'b0010_0000;
   localparam logic [7:0] OP_OR  = 8'b0001_0000;
   localparam logic [7:0] OP_XOR = 8'b0000_1000;
   localparam logic [7:0] OP_NOT = 8'b0000_0100;
   localparam logic [7:0] OP_SHL = 8'b0000_0010;
   localparam logic [7:0] OP_NUL = 8'b0000_0001;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [7:0]   op_onehot = '0;
   logic [W-1:0] b_reg = '0;
   logic [W-1:0] c_reg = '0;
   logic         busy, done, carry, zero, sign, op_error;
   logic [W-1:0] result;

   int n_vec = 0;
   int n_err = 0;

   alu_function_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op_onehot(op_onehot),
      .b_reg(b_reg), .c_reg(c_reg), .busy(busy), .done(done),
      .result(result), .carry(carry), .zero(zero), .sign(sign),
      .op_error(op_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   typedef struct packed {
      logic       err;
      logic       sgn;
      logic       zer;
      logic       cry;
      logic [7:0] res;
   } alu_out_t;

   // Reference ALU straight from the function table.
   function automatic alu_out_t alu_ref(input logic [7:0] op, input logic [7:0] b, input logic [7:0] c);
      alu_out_t o;
      int       sum;
      o = '0;
      case (op)
         OP_ADD: begin sum = int'(b) + int'(c); o.res = sum[7:0]; o.cry = sum > 255; end
         OP_INC: begin sum = int'(b) + 1;      o.res = sum[7:0]; o.cry = sum > 255; end
         OP_AND: o.res = b & c;
         OP_OR:  o.res = b | c;
         OP_XOR: o.res = b ^ c;
         OP_NOT: o.res = ~b;
         OP_SHL: o.res = (b << 1) | (b >> 7);
         OP_NUL: o.res = 8'h00;
         default: o.err = 1'b1;
      endcase
      o.zer = (o.res == 8'h00);
      o.sgn = o.res[7];
      return o;
   endfunction

   // Operation-level model: an accepted start latches after SETTLE+1 further edges.
   logic       m_busy = 0, m_done = 0;
   alu_out_t   m_out = '0;
   logic [7:0] m_op = '0, m_b = '0, m_c = '0;
   int         m_left = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy = 0; m_done = 0; m_out = '0; m_left = 0;
      end else begin
         m_done = 0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_out  = alu_ref(m_op, m_b, m_c);
               m_done = 1;
               m_busy = 0;
            end
         end else if (start) begin
            m_op = op_onehot; m_b = b_reg; m_c = c_reg;
            m_busy = 1;
            m_left = SETTLE + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc_busy",     32'(busy),     32'(m_busy));
         chk("cyc_done",     32'(done),     32'(m_done));
         chk("cyc_result",   32'(result),   32'(m_out.res));
         chk("cyc_carry",    32'(carry),    32'(m_out.cry));
         chk("cyc_zero",     32'(zero),     32'(m_out.zer));
         chk("cyc_sign",     32'(sign),     32'(m_out.sgn));
         chk("cyc_op_error", 32'(op_error), 32'(m_out.err));
      end
   end

   // Called at a negedge; returns at the negedge where done is first seen.
   task automatic run_op(input string nm, input logic [7:0] op, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] er, input logic ec,
                         input logic ez, input logic es, input logic ee);
      int k;
      start = 1'b1; op_onehot = op; b_reg = b; c_reg = c;
      @(negedge clk);
      start = 1'b0;
      k = 1;
      chk({nm, "_busy_e0"}, 32'(busy), 32'd1);
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_latency"}, 32'(k), 32'(LAT));
      chk({nm, "_result"}, 32'(result), 32'(er));
      chk({nm, "_carry"}, 32'(carry), 32'(ec));
      chk({nm, "_zero"}, 32'(zero), 32'(ez));
      chk({nm, "_sign"}, 32'(sign), 32'(es));
      chk({nm, "_op_error"}, 32'(op_error), 32'(ee));
      chk({nm, "_busy_low"}, 32'(busy), 32'd0);
   endtask

   task automatic count_dones(input string nm, input int cycles, input int exp);
      int n;
      n = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (done) n++;
      end
      chk(nm, 32'(n), 32'(exp));
   endtask

   initial begin
      int k;
      repeat (2) @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_outputs", 32'({result, carry, zero, sign, op_error}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_op("add_ff_01", OP_ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0);
      @(negedge clk);
      chk("add_done_one_cycle", 32'(done), 32'd0);
      run_op("inc_7f",  OP_INC, 8'h7F, 8'h00, 8'h80, 0, 0, 1, 0);
      run_op("shl_81",  OP_SHL, 8'h81, 8'h00, 8'h03, 0, 0, 0, 0);
      run_op("and",     OP_AND, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
      run_op("or",      OP_OR,  8'hF0, 8'h3C, 8'hFC, 0, 0, 1, 0);
      run_op("xor",     OP_XOR, 8'hF0, 8'h3C, 8'hCC, 0, 0, 1, 0);
      run_op("not",     OP_NOT, 8'hF0, 8'h3C, 8'h0F, 0, 0, 0, 0);
      run_op("null",    OP_NUL, 8'hF0, 8'h3C, 8'h00, 0, 1, 0, 0);
      run_op("inc_ff",  OP_INC, 8'hFF, 8'h00, 8'h00, 1, 1, 0, 0);
      run_op("bad_two", 8'b0001_1000, 8'hF0, 8'h3C, 8'h00, 0, 1, 0, 1);
      run_op("add_2_3", OP_ADD, 8'h02, 8'h03, 8'h05, 0, 0, 0, 0);
      run_op("bad_zero", 8'h00, 8'h12, 8'h34, 8'h00, 0, 1, 0, 1);
      @(negedge clk);

      // Capture and ignore: operand change and second start during SETTLE.
      start = 1'b1; op_onehot = OP_ADD; b_reg = 8'h10; c_reg = 8'h20;
      @(negedge clk);
      start = 1'b0; b_reg = 8'hFF; op_onehot = OP_XOR;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 3;
      while (!done && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("capture_latency", 32'(k), 32'(LAT));
      chk("capture_result", 32'(result), 32'h30);
      chk("capture_op_error", 32'(op_error), 32'd0);
      count_dones("capture_no_second", 10, 0);

      // Reset abort mid-SETTLE.
      start = 1'b1; op_onehot = OP_ADD; b_reg = 8'h55; c_reg = 8'hB0;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_outputs", 32'({result, carry, zero, sign, op_error}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      count_dones("abort_no_done", 8, 0);
      chk("abort_result_held", 32'(result), 32'd0);

      run_op("post_abort_add", OP_ADD, 8'h80, 8'h80, 8'h00, 1, 1, 0, 0);
      run_op("b2b_add", OP_ADD, 8'h40, 8'h41, 8'h81, 0, 0, 1, 0);
      repeat (3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
